// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST response analyzer:
//   - state_t       : analyzer FSM states (idle, seed, collect, compare)
//   - BIST_POLY_DEF : default Galois feedback mask of the 16-bit MISR
//   - BIST_SEED_DEF : default MISR start value
// -----------------------------------------------------------------------------
package bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEED    = 2'd1,
        S_COLLECT = 2'd2,
        S_COMPARE = 2'd3
    } state_t;

    localparam logic [15:0] BIST_POLY_DEF = 16'hB400;
    localparam logic [15:0] BIST_SEED_DEF = 16'hFFFF;

endpackage : bist_pkg

// File: rtl/bist_misr_step.sv
// -----------------------------------------------------------------------------
// bist_misr_step
// One combinational step of a Galois-style MISR: the signature is shifted
// right, the feedback mask is applied when the bit shifted out was 1, and the
// zero-extended response word is folded in.
// Ports:
//   i_sig   [SIG_W]  current signature
//   i_data  [RESP_W] response word to compact
//   o_sig   [SIG_W]  next signature
// -----------------------------------------------------------------------------
module bist_misr_step
    import bist_pkg::*;
#(
    parameter int               SIG_W  = 16,
    parameter int               RESP_W = 2,
    parameter logic [SIG_W-1:0] POLY   = BIST_POLY_DEF
) (
    input  logic [SIG_W-1:0]  i_sig,
    input  logic [RESP_W-1:0] i_data,
    output logic [SIG_W-1:0]  o_sig
);

    logic [SIG_W-1:0] w_fb;
    logic [SIG_W-1:0] w_ext;

    // NOTE: every variable written in always_comb gets a value before any
    // conditional logic, so no path can leave it unassigned (no latch).
    always_comb begin
        w_fb                = i_sig[0] ? POLY : '0;
        w_ext               = '0;
        w_ext[RESP_W-1:0]   = i_data;
        o_sig               = (i_sig >> 1) ^ w_fb ^ w_ext;
    end

endmodule : bist_misr_step

// File: rtl/bist_response_analyzer.sv
// -----------------------------------------------------------------------------
// bist_response_analyzer
// Compacts a stream of circuit-under-test responses into a MISR signature and
// compares it against a golden value at the end of a session.
// Session flow: IDLE --start--> SEED --> COLLECT (pattern_count accepts)
//               --> COMPARE --> IDLE (done pulses, pass holds).
// Optional build macro: BIST_RA_XMASK_EN adds input resp_xmask; response bits
// whose mask bit is 1 are forced to 0 before compaction.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a session (honoured only in IDLE)
//   pattern_count     responses expected, latched on start
//   golden_sig        expected signature, sampled in COMPARE
//   resp_valid/ready  response handshake (ready only in COLLECT)
//   resp_data         response word
//   resp_xmask        (BIST_RA_XMASK_EN only) unknown-bit mask
//   busy, done, pass  status: not idle / end pulse / signature matched
//   signature         current MISR contents
//   resp_count        responses accepted this session
// -----------------------------------------------------------------------------
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int               RESP_W = 2,
    parameter int               SIG_W  = 16,
    parameter int               CNT_W  = 8,
    parameter logic [SIG_W-1:0] POLY   = BIST_POLY_DEF,
    parameter logic [SIG_W-1:0] SEED   = BIST_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  pattern_count,
    input  logic [SIG_W-1:0]  golden_sig,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_data,
`ifdef BIST_RA_XMASK_EN
    input  logic [RESP_W-1:0] resp_xmask,
`endif
    output logic              resp_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  resp_count
);

    // A response wider than the signature cannot be folded in.
    generate
        if (RESP_W > SIG_W) begin : g_width_check
            $error("bist_response_analyzer: RESP_W must not exceed SIG_W");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_cnt;
    logic [SIG_W-1:0]   r_sig;
    logic               r_pass;
    logic               r_done;

    logic               w_accept;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [RESP_W-1:0]  w_resp_data;
    logic [SIG_W-1:0]   w_sig_next;

`ifdef BIST_RA_XMASK_EN
    assign w_resp_data = resp_data & ~resp_xmask;
`else
    assign w_resp_data = resp_data;
`endif

    assign resp_ready = (r_state == S_COLLECT);
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign pass       = r_pass;
    assign signature  = r_sig;
    assign resp_count = r_cnt;

    assign w_accept   = resp_valid & resp_ready;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    bist_misr_step #(
        .SIG_W  (SIG_W),
        .RESP_W (RESP_W),
        .POLY   (POLY)
    ) u_misr_step (
        .i_sig  (r_sig),
        .i_data (w_resp_data),
        .o_sig  (w_sig_next)
    );

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:    if (start) w_next_state = S_SEED;
            S_SEED:    w_next_state = (r_target == '0) ? S_COMPARE : S_COLLECT;
            // Leave as soon as the accept that reaches the target lands.
            S_COLLECT: if (w_accept && (w_cnt_inc == r_target)) w_next_state = S_COMPARE;
            S_COMPARE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= '0;
            r_cnt    <= '0;
            r_sig    <= '0;
            r_pass   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pass   <= 1'b0;
                        r_target <= pattern_count;
                    end
                end
                S_SEED: begin
                    r_sig <= SEED;
                    r_cnt <= '0;
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_sig <= w_sig_next;
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_COMPARE: begin
                    r_pass <= (r_sig == golden_sig);
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule : bist_response_analyzer

// File: tb/tb_bist_response_analyzer.sv
// -----------------------------------------------------------------------------
// tb_bist_response_analyzer
// Self-checking bench for bist_response_analyzer (default parameters).
// Table-driven sessions, hand-written reset / start-ignore sequences and
// randomized sessions checked against a behavioural MISR model.
// Build with +define+BIST_RA_XMASK_EN to exercise the response mask.
// -----------------------------------------------------------------------------
module tb_bist_response_analyzer;

    localparam logic [15:0] POLY_C = 16'hB400;
    localparam logic [15:0] SEED_C = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pattern_count = '0;
    logic [15:0] golden_sig = '0;
    logic        resp_valid = 1'b0;
    logic [1:0]  resp_data = '0;
    logic [1:0]  xmask_val = '0;
    logic        resp_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [7:0]  resp_count;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic [1:0] stim_data [0:255];

    bist_response_analyzer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pattern_count (pattern_count),
        .golden_sig    (golden_sig),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
`ifdef BIST_RA_XMASK_EN
        .resp_xmask    (xmask_val),
`endif
        .resp_ready    (resp_ready),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .signature     (signature),
        .resp_count    (resp_count)
    );

    always #5 clk = ~clk;

    // done is a one-cycle pulse: count how many cycles it is seen high.
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: shift right, XOR POLY if the dropped bit was 1,
    // XOR in the (masked) response word.
    function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [1:0] d);
        logic [15:0] r;
        r = s / 16'd2;
        if (s % 16'd2 == 16'd1) r = r ^ POLY_C;
        return r ^ {14'd0, d};
    endfunction

    function automatic logic [15:0] model_sig(input int n);
        logic [15:0] s;
        s = SEED_C;
        for (int i = 0; i < n; i++) s = misr_model(s, stim_data[i] & ~xmask_val);
        return s;
    endfunction

    // vmode: 0 = valid always high, 1 = valid toggles 1/0, 2 = random valid.
    task automatic run_session(input int n, input logic [15:0] golden,
                               input logic [15:0] exp_sig, input bit exp_pass,
                               input int vmode, input bit poke_start, input string tag);
        int  acc;
        int  cyc;
        int  done_before;
        bit  v;
        bit  ready_bad;
        golden_sig    = golden;
        done_before   = done_cnt;
        pattern_count = 8'(n);
        start         = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy in seed"}, 32'(busy), 32'd1);
        check({tag, " ready low in seed"}, 32'(resp_ready), 32'd0);
        tick();
        acc = 0;
        cyc = 0;
        ready_bad = 1'b0;
        if (poke_start) begin
            start         = 1'b1;
            pattern_count = 8'd1;
        end
        while (acc < n && cyc < 400) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            resp_valid = v;
            resp_data  = stim_data[acc];
            if (resp_ready !== 1'b1) ready_bad = 1'b1;
            tick();
            cyc++;
            if (v) acc++;
        end
        resp_valid = 1'b0;
        start      = 1'b0;
        if (cyc >= 400) check({tag, " collect timeout"}, 32'(acc), 32'(n));
        check({tag, " ready high while collecting"}, 32'(ready_bad), 32'd0);
        check({tag, " ready low after last accept"}, 32'(resp_ready), 32'd0);
        check({tag, " no early done"}, 32'(done), 32'd0);
        tick();
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " pass"}, 32'(pass), 32'(exp_pass));
        check({tag, " signature"}, 32'(signature), 32'(exp_sig));
        check({tag, " resp_count"}, 32'(resp_count), 32'(n));
        check({tag, " idle"}, 32'(busy), 32'd0);
        tick();
        check({tag, " done pulse ends"}, 32'(done), 32'd0);
        check({tag, " pass held"}, 32'(pass), 32'(exp_pass));
        check({tag, " signature held"}, 32'(signature), 32'(exp_sig));
        check({tag, " single done"}, 32'(done_cnt - done_before), 32'd1);
    endtask

    typedef struct {
        int          n;
        logic [1:0]  d;
        logic [15:0] golden;
        logic [15:0] exp_sig;
        bit          exp_pass;
        int          vmode;
    } vec_t;

    initial begin
        vec_t        vecs [4];
        logic [15:0] e;
        logic [15:0] g;
        int          n;
        int          db;

        vecs[0] = '{n: 0, d: 2'b00, golden: 16'hFFFF, exp_sig: 16'hFFFF, exp_pass: 1'b1, vmode: 0};
        vecs[1] = '{n: 1, d: 2'b01, golden: 16'hCBFE, exp_sig: 16'hCBFE, exp_pass: 1'b1, vmode: 0};
        vecs[2] = '{n: 1, d: 2'b01, golden: 16'h0000, exp_sig: 16'hCBFE, exp_pass: 1'b0, vmode: 0};
        vecs[3] = '{n: 1, d: 2'b01, golden: 16'hCBFE, exp_sig: 16'hCBFE, exp_pass: 1'b1, vmode: 1};

        // Reset state
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset ready", 32'(resp_ready), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset pass", 32'(pass), 32'd0);
        check("reset signature", 32'(signature), 32'd0);
        check("reset resp_count", 32'(resp_count), 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven sessions
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) stim_data[k] = vecs[i].d;
            run_session(vecs[i].n, vecs[i].golden, vecs[i].exp_sig, vecs[i].exp_pass,
                        vecs[i].vmode, 1'b0, $sformatf("vec%0d", i));
        end

        // Four responses, valid toggling each cycle
        for (int k = 0; k < 4; k++) stim_data[k] = 2'($urandom_range(0, 3));
        e = model_sig(4);
        run_session(4, e, e, 1'b1, 1, 1'b0, "toggle4");

        // Start during COLLECT must be ignored (count stays 3, not 1)
        for (int k = 0; k < 3; k++) stim_data[k] = 2'($urandom_range(0, 3));
        e = model_sig(3);
        run_session(3, e, e, 1'b1, 0, 1'b1, "start_ignored");

        // Reset after 2 of 4 accepts
        db = done_cnt;
        pattern_count = 8'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        resp_valid = 1'b1;
        resp_data  = 2'b10;
        tick();
        tick();
        check("midreset count before", 32'(resp_count), 32'd2);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        resp_valid = 1'b0;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset ready", 32'(resp_ready), 32'd0);
        check("midreset signature", 32'(signature), 32'd0);
        check("midreset resp_count", 32'(resp_count), 32'd0);
        check("midreset pass", 32'(pass), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        for (int k = 0; k < 5; k++) tick();
        check("midreset no done", 32'(done_cnt - db), 32'd0);
        check("midreset stays idle", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) stim_data[k] = 2'($urandom_range(0, 3));
        e = model_sig(4);
        run_session(4, e, e, 1'b1, 2, 1'b0, "after_reset");

`ifdef BIST_RA_XMASK_EN
        xmask_val    = 2'b11;
        stim_data[0] = 2'b11;
        run_session(1, 16'hCBFF, 16'hCBFF, 1'b1, 0, 1'b0, "xmask");
        xmask_val    = 2'b00;
`endif

        // Randomized sessions against the model
        for (int r = 0; r < 12; r++) begin
            n = int'($urandom_range(1, 24));
            for (int k = 0; k < n; k++) stim_data[k] = 2'($urandom_range(0, 3));
            e = model_sig(n);
            if ($urandom_range(0, 1) == 1) g = e;
            else                           g = e ^ 16'($urandom_range(1, 65535));
            run_session(n, g, e, (g == e), 2, 1'b0, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_bist_response_analyzer
